// File: rtl/sram_mem_controller.sv
// MEM-stage data memory front end: splits each 32-bit load/store into two
// half-word accesses on an external 256K x 16 asynchronous SRAM and stalls the pipeline meanwhile.
module sram_mem_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOW  = 3'd1,
        S_HIGH = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      r_state;
    logic [16:0] r_idx;
    logic [31:0] r_data;
    logic        r_is_wr;
    logic [31:0] r_buf;
    logic [3:0]  r_wait_cnt;
    logic        r_dq_oe;
    logic [15:0] r_dq_out;
    logic        r_we_n;
    logic [17:0] r_sram_addr;
    logic [31:0] r_read_data;

    logic [31:0] w_offset;
    logic [16:0] w_idx;
    logic        w_req;

    assign w_offset = address - BASE_ADDR;
    assign w_idx    = w_offset[18:2];
    assign w_req    = wr_en | rd_en;

    // Handshake: a request is taken in IDLE (ready drops the same cycle);
    // ready returns high only in DONE, the cycle in which the pipeline advances.
    assign ready = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);

    assign SRAM_DQ     = r_dq_oe ? r_dq_out : 16'hzzzz;
    assign SRAM_ADDR   = r_sram_addr;
    assign SRAM_WE_N   = r_we_n;
    assign SRAM_CE_N   = 1'b0;
    assign SRAM_OE_N   = 1'b0;
    assign SRAM_UB_N   = 1'b0;
    assign SRAM_LB_N   = 1'b0;
    assign read_data   = r_read_data;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_data      <= '0;
            r_is_wr     <= 1'b0;
            r_buf       <= '0;
            r_wait_cnt  <= '0;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
            r_we_n      <= 1'b1;
            r_sram_addr <= '0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // Store wins when both requests are present.
                        r_idx       <= w_idx;
                        r_data      <= write_data;
                        r_is_wr     <= wr_en;
                        r_sram_addr <= {w_idx, 1'b0};
                        r_we_n      <= ~wr_en;
                        r_dq_oe     <= wr_en;
                        r_dq_out    <= write_data[15:0];
                        r_state     <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (!r_is_wr) begin
                        r_buf[15:0] <= SRAM_DQ;
                    end
                    r_sram_addr <= {r_idx, 1'b1};
                    r_dq_out    <= r_data[31:16];
                    r_state     <= S_HIGH;
                end
                S_HIGH: begin
                    r_we_n     <= 1'b1;
                    r_dq_oe    <= 1'b0;
                    r_wait_cnt <= '0;
                    if (WAIT_CYCLES == 0) begin
                        if (!r_is_wr) begin
                            r_read_data <= {SRAM_DQ, r_buf[15:0]};
                        end
                        r_state <= S_DONE;
                    end else begin
                        if (!r_is_wr) begin
                            r_buf[31:16] <= SRAM_DQ;
                        end
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        if (!r_is_wr) begin
                            r_read_data <= r_buf;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: behavioural async SRAM, directed accesses,
// and a completion monitor that checks read_data, stall length and write-strobe length.
module tb_sram_mem_controller;

    localparam int WAIT_C  = 2;
    localparam int EXP_LOW = 3 + WAIT_C;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic [2:0]  dbg_state;

    logic [15:0] sram_mem [0:262143];

    logic [31:0] exp_q[$];
    logic [31:0] we_q[$];
    logic [31:0] exp_rd;

    int n_checks = 0;
    int n_errors = 0;
    int mon_low  = 0;
    int mon_we   = 0;

    sram_mem_controller #(
        .BASE_ADDR  (32'd1024),
        .WAIT_CYCLES(WAIT_C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N),
        .o_dbg_state(dbg_state)
    );

    // Clock / SRAM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign SRAM_DQ = SRAM_WE_N ? sram_mem[SRAM_ADDR] : 16'hzzzz;

    always @(negedge clk) begin
        if (!SRAM_WE_N) sram_mem[SRAM_ADDR] = SRAM_DQ;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a completion is the first ready-high sample after a stall.
    always @(negedge clk) begin
        logic [31:0] e_rd;
        logic [31:0] e_we;
        if (rst) begin
            mon_low = 0;
            mon_we  = 0;
        end else if (!ready) begin
            mon_low++;
            if (!SRAM_WE_N) mon_we++;
        end else if (mon_low != 0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_completion: got read_data 0x%08h, required no completion", read_data);
            end else begin
                e_rd = exp_q.pop_front();
                e_we = we_q.pop_front();
                chk("done_read_data", read_data, e_rd);
                chk("stall_cycles", 32'(mon_low), 32'(EXP_LOW));
                chk("we_low_cycles", 32'(mon_we), e_we);
            end
            mon_low = 0;
            mon_we  = 0;
        end
    end

    // Driver tasks (called at posedge + #1 with the controller in IDLE)
    task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic scramble);
        bit done = 0;
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (scramble) begin
            address    = addr + 32'd8;
            write_data = 32'h0;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL completion_timeout: ready stayed 0, required 1 within 40 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic both, input logic scramble);
        exp_q.push_back(exp_rd);
        we_q.push_back(32'd2);
        issue(1'b1, both, addr, data, scramble);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] expv);
        exp_q.push_back(expv);
        we_q.push_back(32'd0);
        exp_rd = expv;
        issue(1'b0, 1'b1, addr, 32'h0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        exp_rd     = 32'h0;
        sram_mem[4]  = 16'h1111;
        sram_mem[5]  = 16'h2222;
        sram_mem[16] = 16'h5555;
        sram_mem[17] = 16'h6666;
        sram_mem[20] = 16'h7777;
        sram_mem[21] = 16'h8888;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(ready), 32'd1);
            chk("rst_read_data", read_data, 32'h0);
            chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
            chk("rst_state", 32'(dbg_state), 32'd0);
        end
        chk("rst_sram_addr", 32'(SRAM_ADDR), 32'h0);
        chk("tie_offs", {28'h0, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'h0);
        @(posedge clk);
        #1;

        do_write(32'd1032, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("store_low_half", 32'(sram_mem[4]), 32'h0000BEEF);
        chk("store_high_half", 32'(sram_mem[5]), 32'h0000DEAD);

        do_read(32'd1032, 32'hDEADBEEF);

        // wr_en and rd_en together behaves as a store
        do_write(32'd1040, 32'h12345678, 1'b1, 1'b0);
        chk("both_low_half", 32'(sram_mem[8]), 32'h00005678);
        chk("both_high_half", 32'(sram_mem[9]), 32'h00001234);
        do_read(32'd1040, 32'h12345678);

        // Inputs change right after acceptance; latched values must be used
        do_write(32'd1048, 32'hCAFEF00D, 1'b0, 1'b1);
        chk("latched_low", 32'(sram_mem[12]), 32'h0000F00D);
        chk("latched_high", 32'(sram_mem[13]), 32'h0000CAFE);
        chk("other_low_untouched", 32'(sram_mem[16]), 32'h00005555);
        chk("other_high_untouched", 32'(sram_mem[17]), 32'h00006666);
        do_read(32'd1049, 32'hCAFEF00D);

        // Address below BASE_ADDR wraps to the top SRAM word
        do_write(32'd1020, 32'hA5A55A5A, 1'b0, 1'b0);
        chk("wrap_low", 32'(sram_mem[18'h3FFFE]), 32'h00005A5A);
        chk("wrap_high", 32'(sram_mem[18'h3FFFF]), 32'h0000A5A5);
        do_read(32'd1020, 32'hA5A55A5A);

        // Reset during the high half of a store
        wr_en      = 1'b1;
        address    = 32'd1064;
        write_data = 32'h11112222;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_in_high", 32'(dbg_state), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("mid_rst_read_data", read_data, 32'h0);
        exp_rd = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_read(32'd1064, 32'h88882222);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
